pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_in_sync.sv | 64 ++++++
 rtl/pwm_capture.sv | 133 +++++++++++++
 tb/tb_pwm_capture.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block.
//   SYNC_STAGES : depth of the pwm_in metastability synchronizer
//   FILTER_LEN  : consecutive equal samples needed by the optional glitch filter
//   pwm_state_e : measurement FSM states
package pwm_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_LEN  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StMeasure
    } pwm_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizer plus optional glitch filter for the asynchronous PWM input.
// Optional feature macro: PWM_CAPTURE_GLITCH_FILTER_EN (filter present when defined).
//   clk     : sole clock
//   rst_n   : asynchronous active-low reset
//   pwm_i   : raw asynchronous PWM waveform
//   level_o : filtered level (synchronizer output when the filter is absent)
module pwm_in_sync
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Window = current synchronized sample plus the previous FILTER_LEN-1 samples.
    // Output follows only when the whole window agrees, otherwise it holds.
    logic [FILTER_LEN-2:0] hist_q;
    logic [FILTER_LEN-1:0] window;
    logic                  level_q;
    logic                  level_d;

    assign window = {hist_q, synced};

    always_comb begin
        level_d = level_q;
        if (window == '1) begin
            level_d = 1'b1;
        end else if (window == '0) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            level_q <= 1'b0;
        end else begin
            hist_q  <= window[FILTER_LEN-2:0];
            level_q <= level_d;
        end
    end

    // Combinational output keeps the added latency at FILTER_LEN-1 cycles.
    assign level_o = level_d;
`else
    assign level_o = synced;
`endif

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture.
// Measures clk cycles between consecutive rising edges of the filtered input and the
// number of those cycles spent high. Optional feature macro: PWM_CAPTURE_GLITCH_FILTER_EN
// (3-sample glitch filter in front of the edge detector).
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : measurement enable; low forces idle and holds the outputs
//   pwm_in     : asynchronous PWM waveform
//   period_out : cycles between the last two accepted rising edges
//   high_out   : high cycles within that period
//   valid      : one-cycle pulse when period_out/high_out update
//   timeout    : sticky, no rising edge for 2^bit_width-1 cycles; cleared by next result
//   level_out  : current filtered input level
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned bit_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 pwm_in,
    output logic [bit_width-1:0] period_out,
    output logic [bit_width-1:0] high_out,
    output logic                 valid,
    output logic                 timeout,
    output logic                 level_out
);

    localparam logic [bit_width-1:0] CntMax = '1;
    localparam logic [bit_width-1:0] CntOne = bit_width'(1);

    logic level;
    logic level_prev_q;
    logic rise;

    pwm_state_e           state_q, state_d;
    logic [bit_width-1:0] period_cnt_q, period_cnt_d;
    logic [bit_width-1:0] high_cnt_q, high_cnt_d;
    logic [bit_width-1:0] period_q, period_d;
    logic [bit_width-1:0] high_q, high_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;

    pwm_in_sync u_pwm_in_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_i   (pwm_in),
        .level_o (level)
    );

    assign rise = level & ~level_prev_q;

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_d     = period_q;
        high_d       = high_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (rise) begin
                    // First edge only opens the measurement window.
                    state_d      = StMeasure;
                    period_cnt_d = CntOne;
                    high_cnt_d   = CntOne;
                end
            end
            StMeasure: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (rise) begin
                    period_d     = period_cnt_q;
                    high_d       = high_cnt_q;
                    valid_d      = 1'b1;
                    timeout_d    = 1'b0;
                    period_cnt_d = CntOne;
                    high_cnt_d   = CntOne;
                end else if (period_cnt_q == CntMax) begin
                    // Saturate instead of wrapping; rearm for a fresh first edge.
                    timeout_d = 1'b1;
                    state_d   = StArmed;
                end else begin
                    // high_cnt moves with period_cnt or not at all, so high <= period.
                    period_cnt_d = period_cnt_q + CntOne;
                    high_cnt_d   = high_cnt_q + bit_width'(level);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            level_prev_q <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_q     <= '0;
            high_q       <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_prev_q <= level;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign level_out  = level;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. The reference model records the driven waveform
// and enable history per cycle and derives each expected result from the previous
// accepted rising edge: period = edge distance, high = count of high samples between.
module tb_pwm_capture;

    localparam int unsigned W = 8;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int F    = 2;
    localparam bit FILT = 1'b1;
`else
    localparam int F    = 0;
    localparam bit FILT = 1'b0;
`endif
    // Driven sample index to visible valid: 2 sync flops (+ filter delay).
    localparam int LAT  = 2 + F;
    localparam int MAXC = 16384;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         pwm_in;
    logic [W-1:0] period_out;
    logic [W-1:0] high_out;
    logic         valid;
    logic         timeout;
    logic         level_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit hist [MAXC];
    bit en_h [MAXC];

    always #5 clk = ~clk;

    pwm_capture #(.bit_width(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .timeout    (timeout),
        .level_out  (level_out)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive one sample (p) and record the model's view of it (mp) plus effective enable.
    task automatic step(input bit p, input bit mp);
        if (cyc >= MAXC - 1) begin
            $display("FAIL history_overflow: cycle %0d exceeds model storage %0d", cyc, MAXC);
            $fatal(1);
        end
        pwm_in    = p;
        hist[cyc] = mp;
        en_h[cyc] = enable && rst_n;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected publish visible after sample m: a rising edge at e = m-LAT that was seen
    // while enabled, following an earlier accepted edge no more than 255 cycles back with
    // enable held continuously in between.
    function automatic void exp_pub(input int m, output bit v, output int per, output int hi);
        int e;
        v   = 1'b0;
        per = 0;
        hi  = 0;
        e   = m - LAT;
        if (e < 1) return;
        if (!(hist[e] && !hist[e-1])) return;
        if (!(en_h[e+1+F] && en_h[e+2+F])) return;
        for (int j = e - 1; j >= 1 && (e - j) <= 255; j--) begin
            if (!en_h[j+2+F]) return;
            if (hist[j] && !hist[j-1] && en_h[j+1+F]) begin
                v   = 1'b1;
                per = e - j;
                for (int k = j; k < e; k++) hi += int'(hist[k]);
                return;
            end
        end
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;
        #2;
        repeat (3) step(1'b1, 1'b1);
        checks++;
        if (period_out !== '0 || high_out !== '0 || valid !== 1'b0 || timeout !== 1'b0 ||
            level_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got p=%0d h=%0d v=%b t=%b l=%b required all 0",
                     period_out, high_out, valid, timeout, level_out);
        end
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        checks++;
        if (valid !== 1'b0 || level_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got v=%b l=%b required 0/0", valid, level_out);
        end
    endtask

    task automatic test_basic();
        bit ev;
        int ep, eh, nv, first;
        bit p;
        nv = 0;
        first = -1;
        enable = 1'b1;
        for (int i = 0; i < 6 + 80; i++) begin
            p = (i >= 6) && (((i - 6) % 10) < 3);
            step(p, p);
            exp_pub(cyc - 1, ev, ep, eh);
            checks++;
            if (valid !== ev) begin
                errors++;
                $display("FAIL basic_valid at %0d: got %b required %b", i, valid, ev);
            end else if (ev) begin
                checks++;
                if (period_out !== ep[W-1:0] || high_out !== eh[W-1:0]) begin
                    errors++;
                    $display("FAIL basic_model at %0d: got %0d/%0d required %0d/%0d",
                             i, period_out, high_out, ep, eh);
                end
            end
            if (valid === 1'b1) begin
                nv++;
                if (first < 0) first = i;
                checks++;
                if (period_out !== 8'd10 || high_out !== 8'd3) begin
                    errors++;
                    $display("FAIL basic_10_3 at %0d: got %0d/%0d required 10/3",
                             i, period_out, high_out);
                end
            end
        end
        checks++;
        if (nv !== 7 || first !== 16 + LAT) begin
            errors++;
            $display("FAIL basic_count: got %0d valids first at %0d required 7 first at %0d",
                     nv, first, 16 + LAT);
        end
    endtask

    task automatic test_random();
        bit ev;
        int ep, eh, per, hi;
        bit wq[$];
        for (int i = 0; i < 30; i++) begin
            if (FILT) begin
                per = int'($urandom_range(40, 6));
                hi  = int'($urandom_range(per - 3, 3));
            end else if (i < 3) begin
                per = 2;
                hi  = 1;
            end else begin
                per = int'($urandom_range(40, 2));
                hi  = int'($urandom_range(per - 1, 1));
            end
            for (int k = 0; k < per; k++) wq.push_back(k < hi);
        end
        foreach (wq[i]) begin
            step(wq[i], wq[i]);
            exp_pub(cyc - 1, ev, ep, eh);
            checks++;
            if (valid !== ev) begin
                errors++;
                $display("FAIL random_valid at %0d: got %b required %b", i, valid, ev);
            end else if (ev) begin
                checks++;
                if (period_out !== ep[W-1:0] || high_out !== eh[W-1:0]) begin
                    errors++;
                    $display("FAIL random_meas at %0d: got %0d/%0d required %0d/%0d",
                             i, period_out, high_out, ep, eh);
                end
            end
            checks++;
            if (level_out !== hist[cyc-2-F]) begin
                errors++;
                $display("FAIL random_level at %0d: got %b required %b",
                         i, level_out, hist[cyc-2-F]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ev;
        int ep, eh, last_ep, last_eh, nv;
        bit p;
        last_ep = 0;
        last_eh = 0;
        nv = 0;
        for (int i = 0; i < 5 + 300; i++) begin
            p = (i >= 5);
            step(p, p);
            exp_pub(cyc - 1, ev, ep, eh);
            checks++;
            if (valid !== ev) begin
                errors++;
                $display("FAIL timeout_valid at %0d: got %b required %b", i, valid, ev);
            end
            if (ev) begin
                last_ep = ep;
                last_eh = eh;
                nv++;
            end
            if (i == 5 + LAT + 254) begin
                checks++;
                if (timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early at %0d: got %b required 0", i, timeout);
                end
            end
            if (i == 5 + LAT + 255) begin
                checks++;
                if (timeout !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_set at %0d: got %b required 1", i, timeout);
                end
            end
        end
        checks++;
        if (timeout !== 1'b1 || level_out !== 1'b1 || nv !== 1 ||
            period_out !== last_ep[W-1:0] || high_out !== last_eh[W-1:0]) begin
            errors++;
            $display("FAIL timeout_final: got t=%b l=%b p=%0d h=%0d required 1/1/%0d/%0d (%0d pubs)",
                     timeout, level_out, period_out, high_out, last_ep, last_eh, nv);
        end
    endtask

    task automatic test_enable_drop();
        bit ev;
        int ep, eh, npost;
        bit p, off;
        npost = 0;
        for (int i = 0; i < 4 + 120; i++) begin
            off    = (i >= 59) && (i < 79);
            enable = !off;
            p      = (i >= 4) && (((i - 4) % 12) < 5);
            step(p, p);
            exp_pub(cyc - 1, ev, ep, eh);
            checks++;
            if (valid !== ev) begin
                errors++;
                $display("FAIL enable_valid at %0d: got %b required %b", i, valid, ev);
            end else if (ev) begin
                checks++;
                if (period_out !== 8'd12 || high_out !== 8'd5) begin
                    errors++;
                    $display("FAIL enable_meas at %0d: got %0d/%0d required 12/5",
                             i, period_out, high_out);
                end
            end
            if (off) begin
                checks++;
                if (valid !== 1'b0 || period_out !== 8'd12 || high_out !== 8'd5 ||
                    timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL enable_hold at %0d: got v=%b %0d/%0d t=%b required 0 12/5 0",
                             i, valid, period_out, high_out, timeout);
                end
            end
            if (i >= 79 && valid === 1'b1) npost++;
        end
        enable = 1'b1;
        checks++;
        if (npost !== 2) begin
            errors++;
            $display("FAIL enable_resume: got %0d valids after resume required 2", npost);
        end
    endtask

    task automatic test_reset_mid();
        bit ev;
        int ep, eh, nv, first;
        bit p;
        nv = 0;
        first = -1;
        for (int i = 0; i < 4 + 27 + 2; i++) begin
            p = (i >= 4) && (((i - 4) % 9) < 4);
            step(p, p);
            exp_pub(cyc - 1, ev, ep, eh);
            checks++;
            if (valid !== ev) begin
                errors++;
                $display("FAIL rstmid_pre_valid at %0d: got %b required %b", i, valid, ev);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (period_out !== '0 || high_out !== '0 || valid !== 1'b0 || timeout !== 1'b0 ||
            level_out !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got p=%0d h=%0d v=%b t=%b l=%b required all 0",
                     period_out, high_out, valid, timeout, level_out);
        end
        repeat (3) begin
            step(1'b0, 1'b0);
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_in_reset: got valid %b required 0", valid);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4 + 36; i++) begin
            p = (i >= 4) && (((i - 4) % 9) < 4);
            step(p, p);
            exp_pub(cyc - 1, ev, ep, eh);
            checks++;
            if (valid !== ev) begin
                errors++;
                $display("FAIL rstmid_valid at %0d: got %b required %b", i, valid, ev);
            end else if (ev) begin
                checks++;
                if (period_out !== 8'd9 || high_out !== 8'd4) begin
                    errors++;
                    $display("FAIL rstmid_meas at %0d: got %0d/%0d required 9/4",
                             i, period_out, high_out);
                end
            end
            if (valid === 1'b1) begin
                nv++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (nv !== 3 || first !== 13 + LAT) begin
            errors++;
            $display("FAIL rstmid_restart: got %0d valids first at %0d required 3 first at %0d",
                     nv, first, 13 + LAT);
        end
    endtask

    task automatic test_glitch();
        bit ev;
        int ep, eh, nv, k;
        bit raw, mp;
        nv = 0;
        enable = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 5 + 96; i++) begin
            raw = 1'b0;
            mp  = 1'b0;
            if (i >= 5) begin
                k   = (i - 5) % 16;
                raw = (k < 4) || (k == 9);
                mp  = FILT ? (k < 4) : raw;
            end
            step(raw, mp);
            exp_pub(cyc - 1, ev, ep, eh);
            checks++;
            if (valid !== ev) begin
                errors++;
                $display("FAIL glitch_valid at %0d: got %b required %b", i, valid, ev);
            end else if (ev) begin
                checks++;
                if (period_out !== ep[W-1:0] || high_out !== eh[W-1:0]) begin
                    errors++;
                    $display("FAIL glitch_model at %0d: got %0d/%0d required %0d/%0d",
                             i, period_out, high_out, ep, eh);
                end
            end
            if (valid === 1'b1) begin
                nv++;
                if (FILT) begin
                    checks++;
                    if (period_out !== 8'd16 || high_out !== 8'd4) begin
                        errors++;
                        $display("FAIL glitch_filtered at %0d: got %0d/%0d required 16/4",
                                 i, period_out, high_out);
                    end
                end else if (nv == 1) begin
                    checks++;
                    if (period_out !== 8'd9 || high_out !== 8'd4) begin
                        errors++;
                        $display("FAIL glitch_edge at %0d: got %0d/%0d required 9/4",
                                 i, period_out, high_out);
                    end
                end
            end
        end
        checks++;
        if (nv !== (FILT ? 5 : 11)) begin
            errors++;
            $display("FAIL glitch_count: got %0d valids required %0d", nv, FILT ? 5 : 11);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
